// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a 2-entry skid buffer and a halt/resume FSM.
// Optional macro DECODE_ILLEGAL_CHECK_EN flags the all-ones prefix as illegal and suppresses halt on it.
module decode_stage #(
  parameter int              PFIX_W     = 2,
  parameter int              OP_W       = 6,
  parameter int              REG_W      = 4,
  parameter int              IMM_W      = 16,
  parameter int              DATA_W     = 32,
  parameter int              PC_W       = 32,
  parameter logic [OP_W-1:0] HLT_OPCODE = 6'b001011,
  parameter int              IMM_SEXT   = 1,
  localparam int             INSTR_W    = PFIX_W + OP_W + 2*REG_W + IMM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               resume,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PFIX_W-1:0]  out_pfix,
  output logic [OP_W-1:0]    out_opcode,
  output logic [REG_W-1:0]   out_rs,
  output logic [REG_W-1:0]   out_rd,
  output logic [DATA_W-1:0]  out_imm,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_halt,
  output logic               out_illegal,
  output logic               halted
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] HALT_PEND = 2'd1;
  localparam logic [1:0] HALTED    = 2'd2;

  typedef struct packed {
    logic [PFIX_W-1:0] pfix;
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
    logic              halt;
    logic              ill;
  } entry_t;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm);
    logic [DATA_W-1:0] r;
    r = '0;
    r[IMM_W-1:0] = imm;
    for (int i = IMM_W; i < DATA_W; i++) r[i] = (IMM_SEXT != 0) && imm[IMM_W-1];
    return r;
  endfunction

  function automatic entry_t decode(input logic [INSTR_W-1:0] ins, input logic [PC_W-1:0] pc);
    entry_t e;
    e.pfix = ins[INSTR_W-1 -: PFIX_W];
    e.op   = ins[INSTR_W-PFIX_W-1 -: OP_W];
    e.rs   = ins[INSTR_W-PFIX_W-OP_W-1 -: REG_W];
    e.rd   = ins[IMM_W+REG_W-1 -: REG_W];
    e.imm  = ext_imm(ins[IMM_W-1:0]);
    e.pc   = pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
    e.ill  = &e.pfix;
    e.halt = (e.op == HLT_OPCODE) && !e.ill;
`else
    e.ill  = 1'b0;
    e.halt = (e.op == HLT_OPCODE);
`endif
    return e;
  endfunction

  entry_t     main_q, main_d, skid_q, skid_d, new_e;
  logic       main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [1:0] state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       in_fire, out_fire;

  always_comb begin
    in_fire    = in_valid && in_ready_q && !flush;
    out_fire   = main_vld_q && out_ready;
    new_e      = decode(in_instr, in_pc);
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    state_d    = state_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_fire) begin
      // Main slot frees up: the skid entry is older than anything arriving now.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = in_fire;
        if (in_fire) skid_d = new_e;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) main_d = new_e;
      end
    end else if (in_fire) begin
      skid_d     = new_e;
      skid_vld_d = 1'b1;
    end

    case (state_q)
      RUN:       if (in_fire && new_e.halt) state_d = HALT_PEND;
      HALT_PEND: begin
        if (flush) state_d = RUN;
        else if (out_fire && main_q.halt) state_d = HALTED;
      end
      HALTED:    if (resume) state_d = RUN;
      default:   state_d = RUN;
    endcase

    // Registered ready: a free skid slot guarantees room even if out_ready stays low.
    in_ready_d = !skid_vld_d && (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      state_q    <= RUN;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_vld_q;
  assign out_pfix    = main_q.pfix;
  assign out_opcode  = main_q.op;
  assign out_rs      = main_q.rs;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_pc      = main_q.pc;
  assign out_halt    = main_q.halt;
  assign out_illegal = main_q.ill;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_decode_stage;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, resume = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, out_halt, out_illegal, halted;
  logic [1:0]  out_pfix;
  logic [5:0]  out_opcode;
  logic [3:0]  out_rs, out_rd;
  logic [31:0] out_imm, out_pc;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .resume(resume),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pfix(out_pfix),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rd(out_rd), .out_imm(out_imm),
    .out_pc(out_pc), .out_halt(out_halt), .out_illegal(out_illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  pfix;
    logic [5:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        halt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t got, want;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [81:0] act, input logic [81:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] pf, input logic [5:0] op, input logic [3:0] rs,
                              input logic [3:0] rd, input logic [31:0] imm, input logic [31:0] pc,
                              input logic h, input logic il);
    exp_t e;
    e = '{pfix: pf, op: op, rs: rs, rd: rd, imm: imm, pc: pc, halt: h, ill: il};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got = '{pfix: out_pfix, op: out_opcode, rs: out_rs, rd: out_rd, imm: out_imm,
              pc: out_pc, halt: out_halt, ill: out_illegal};
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %h expected no entry", got);
      end else begin
        want = sb.pop_front();
        chk("out_entry", got, want);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: instr %h not accepted, required accept within 50 clks", ins);
      in_valid = 1'b0;
    end else begin
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out_imm", out_imm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("first_cycle_in_ready", in_ready, 0);

    // Full-rate stream
    out_ready = 1'b1;
    send(32'h01234567, 32'h100, mk(2'd0, 6'h01, 4'h2, 4'h3, 32'h00004567, 32'h100, 0, 0));
    send(32'h02ABCDEF, 32'h104, mk(2'd0, 6'h02, 4'hA, 4'hB, 32'hFFFFCDEF, 32'h104, 0, 0));
    send(32'h0300FFFF, 32'h108, mk(2'd0, 6'h03, 4'h0, 4'h0, 32'hFFFFFFFF, 32'h108, 0, 0));
    idle();
    @(negedge clk); #1;
    chk("stream_tput", sb.size(), 0);

    // Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(32'h45128001, 32'h200, mk(2'd1, 6'h05, 4'h1, 4'h2, 32'hFFFF8001, 32'h200, 0, 0));
        send(32'h86347FFF, 32'h204, mk(2'd2, 6'h06, 4'h3, 4'h4, 32'h00007FFF, 32'h204, 0, 0));
        send(32'h07560000, 32'h208, mk(2'd0, 6'h07, 4'h5, 4'h6, 32'h00000000, 32'h208, 0, 0));
        send(32'h3F9A1234, 32'h20C, mk(2'd0, 6'h3F, 4'h9, 4'hA, 32'h00001234, 32'h20C, 0, 0));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_held_pc", out_pc, 32'h200);
        chk("bp_held_imm", out_imm, 32'hFFFF8001);
        out_ready = 1'b1;
      end
    join
    @(negedge clk); #1;
    chk("bp_drain", sb.size(), 0);

    // Resume outside HALTED has no effect
    @(posedge clk); #1;
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("resume_in_run", {halted, in_ready}, 2'b01);

    // Halt then resume
    send(32'h0B000000, 32'h300, mk(2'd0, 6'h0B, 4'h0, 4'h0, 32'h0, 32'h300, 1, 0));
    @(posedge clk); #1;
    in_instr = 32'h01000001;
    in_pc    = 32'h304;
    chk("halt_pend_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("halted_set", {halted, in_ready, out_valid}, 3'b100);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("halted_hold", {halted, out_valid}, 2'b10);
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
    chk("resume_in_ready", {halted, in_ready}, 2'b01);
    sb.push_back(mk(2'd0, 6'h01, 4'h0, 4'h0, 32'h1, 32'h304, 0, 0));
    idle();
    @(negedge clk); #1;
    chk("resume_drain", sb.size(), 0);

    // Flush in HALT_PEND with main and skid full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0A110022, 32'h400, mk(2'd0, 6'h0A, 4'h1, 4'h1, 32'h0022, 32'h400, 0, 0));
    send(32'h0B000000, 32'h404, mk(2'd0, 6'h0B, 4'h0, 4'h0, 32'h0, 32'h404, 1, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pend_state", {in_ready, out_valid, halted}, 3'b010);
    chk("pend_held_pc", out_pc, 32'h400);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_result", {out_valid, halted, in_ready}, 3'b001);
    sb.delete();
    out_ready = 1'b1;
    send(32'h05FEDCBA, 32'h408, mk(2'd0, 6'h05, 4'hF, 4'hE, 32'hFFFFDCBA, 32'h408, 0, 0));
    idle();

    // Reset mid-operation
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0C123456;
    in_pc     = 32'h500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency_1", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {out_valid, in_ready, halted, out_opcode}, 0);
    chk("async_rst_data", {out_imm, out_pc}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 0);
    out_ready = 1'b1;
    send(32'h1D238000, 32'h504, mk(2'd0, 6'h1D, 4'h2, 4'h3, 32'hFFFF8000, 32'h504, 0, 0));
    idle();
    chk("post_rst_imm", {out_valid, out_imm}, {1'b1, 32'hFFFF8000});

    // Reserved prefix on a halt opcode
`ifdef DECODE_ILLEGAL_CHECK_EN
    send(32'hCB000000, 32'h600, mk(2'd3, 6'h0B, 4'h0, 4'h0, 32'h0, 32'h600, 0, 1));
    idle();
    @(posedge clk); #1;
    chk("illegal_no_halt", {halted, in_ready}, 2'b01);
`else
    send(32'hCB000000, 32'h600, mk(2'd3, 6'h0B, 4'h0, 4'h0, 32'h0, 32'h600, 1, 0));
    idle();
    @(posedge clk); #1;
    chk("prefix_halt", {halted, in_ready}, 2'b10);
    resume = 1'b1;
    @(posedge clk); #1;
    resume = 1'b0;
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1 chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
